// File: rtl/dcache_write_buffer_pkg.sv
// Shared constants for the d-cache posted write buffer.
//   PHYS_ADDR_SIZE : physical byte-address width
//   WBUF_LINE_W    : cache line width in bits
//   WBUF_DEPTH     : default number of buffered lines
//   WBUF_IDLE/DRAIN/FLUSH : controller state encoding
package dcache_write_buffer_pkg;

    localparam int PHYS_ADDR_SIZE = 32;
    localparam int WBUF_LINE_W    = 128;
    localparam int WBUF_DEPTH     = 4;

    typedef logic [1:0] wbuf_state_t;

    localparam logic [1:0] WBUF_IDLE  = 2'd0;
    localparam logic [1:0] WBUF_DRAIN = 2'd1;
    localparam logic [1:0] WBUF_FLUSH = 2'd2;

endpackage

// File: rtl/wbuf_match.sv
// Address comparator with age-priority select over the buffer entries.
//   valids : per-entry valid bits
//   addrs  : per-entry line addresses
//   head   : index of the oldest entry (age 0)
//   probe  : address being searched for
//   hit    : some valid entry matches
//   index  : the newest matching entry
//   is_head: the newest match is the head entry
module wbuf_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valids,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [PTR_W-1:0]             head,
    input  logic [ADDR_W-1:0]            probe,
    output logic                         hit,
    output logic [PTR_W-1:0]             index,
    output logic                         is_head
);

    logic [DEPTH-1:0] match;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_cmp
            assign match[g] = valids[g] && (addrs[g] == probe);
        end
    endgenerate

    // Age is the distance from head in ring order; the largest age among
    // matches is the most recently written copy.
    logic [PTR_W-1:0] age;
    logic [PTR_W-1:0] best_age;

    always_comb begin
        hit      = 1'b0;
        index    = head;
        age      = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = PTR_W'(i) - head;
            if (match[i] && (!hit || age > best_age)) begin
                hit      = 1'b1;
                index    = PTR_W'(i);
                best_age = age;
            end
        end
        is_head = hit && (index == head);
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between d-cache eviction and the memory arbiter.
// Evicted dirty lines are accepted in one cycle, drained to memory in FIFO
// order, and refill lookups see the newest buffered copy.
//   clock, rst                 : clock, async active-high reset
//   enq_valid/addr/data/ready  : eviction input handshake
//   lookup_valid/addr/hit/data : combinational refill probe
//   flush/flush_done           : drain-all request and completion pulse
//   mem_wr_req/addr/data/ack   : head entry offered to the arbiter
//   count/empty/full           : occupancy
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH,
    parameter int ADDR_W = PHYS_ADDR_SIZE - 4,
    parameter int LINE_W = WBUF_LINE_W
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       enq_valid,
    input  logic [ADDR_W-1:0]          enq_addr,
    input  logic [LINE_W-1:0]          enq_data,
    output logic                       enq_ready,
    input  logic                       lookup_valid,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [LINE_W-1:0]          lookup_data,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       mem_wr_req,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [LINE_W-1:0]          mem_wr_data,
    input  logic                       mem_wr_ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][LINE_W-1:0] data_q;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    wbuf_state_t                  state;
    wbuf_state_t                  state_next;
    logic [CNT_W-1:0]             count_next;
    logic                         done_next;

    logic accept, pop, coalesce, alloc;

    // ---------------- occupancy / handshakes ----------------
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    // Registers only: a same-cycle ack must not open the door for an enqueue.
    assign enq_ready  = !full && (state != WBUF_FLUSH);
    assign accept     = enq_valid && enq_ready;
    assign mem_wr_req = !empty;
    assign pop        = mem_wr_req && mem_wr_ack;

    assign mem_wr_addr = mem_wr_req ? addr_q[head] : '0;
    assign mem_wr_data = mem_wr_req ? data_q[head] : '0;

    // ---------------- coalesce search ----------------
    logic             c_hit, c_is_head;
    logic [PTR_W-1:0] c_idx;

    wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match_enq (
        .valids  (valid),
        .addrs   (addr_q),
        .head    (head),
        .probe   (enq_addr),
        .hit     (c_hit),
        .index   (c_idx),
        .is_head (c_is_head)
    );

    // The head may be on the bus, so a match on it alone forces a new slot.
    // If the newest match is the head, no non-head copy exists.
    assign coalesce = accept && c_hit && !c_is_head;
    assign alloc    = accept && !coalesce;

    // ---------------- lookup ----------------
    logic             l_hit, l_is_head;
    logic [PTR_W-1:0] l_idx;

    wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match_lkp (
        .valids  (valid),
        .addrs   (addr_q),
        .head    (head),
        .probe   (lookup_addr),
        .hit     (l_hit),
        .index   (l_idx),
        .is_head (l_is_head)
    );

    // Same-cycle enqueue is newer than anything stored, so it wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        if (lookup_valid) begin
            if (accept && (enq_addr == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = enq_data;
            end else if (l_hit) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[l_idx];
            end
        end
    end

    // ---------------- next count / state ----------------
    always_comb begin
        count_next = count;
        case ({alloc, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Once the buffer will be empty, any pending flush completes and the
    // controller idles; otherwise a flush (new or ongoing) holds FLUSH.
    // A flush raised in IDLE together with an allocate goes to FLUSH.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (count_next == '0) begin
            state_next = WBUF_IDLE;
            done_next  = flush || (state == WBUF_FLUSH);
        end else if (flush || state == WBUF_FLUSH) begin
            state_next = WBUF_FLUSH;
        end else begin
            state_next = WBUF_DRAIN;
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            valid      <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= WBUF_IDLE;
            flush_done <= 1'b0;
        end else begin
            // Alloc and pop never touch the same slot: pop needs a non-empty
            // buffer, and then tail != head unless full (no alloc).
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            count      <= count_next;
            state      <= state_next;
            flush_done <= done_next;
        end
    end

    // Payload storage is qualified by the valid bits and needs no reset.
    always_ff @(posedge clock) begin
        if (alloc) begin
            addr_q[tail] <= enq_addr;
            data_q[tail] <= enq_data;
        end else if (coalesce) begin
            data_q[c_idx] <= enq_data;
        end
    end

endmodule
